hazard_issue_ctrl: RTL and testbench

//  In-order issue controller; the consumer side of the hazard-check logic.

---
 rtl/hazard_pkg.sv | 16 +
 rtl/instr_reg_use.sv | 25 ++
 rtl/hazard_issue_ctrl.sv | 79 +++++++
 tb/tb_hazard_issue_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: opcodes, hazard bit positions and instruction field ranges shared by the issue controller
package hazard_pkg;
  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_ADD   = 2'b11;
  localparam int HZ_RAW = 2;
  localparam int HZ_WAR = 1;
  localparam int HZ_WAW = 0;
  localparam int OP_HI = 7;
  localparam int OP_LO = 6;
  localparam int RA_HI = 5;
  localparam int RA_LO = 3;
  localparam int RB_HI = 2;
  localparam int RB_LO = 0;
endpackage

// File: rtl/instr_reg_use.sv
// instr_reg_use: decodes an instruction into source/destination register masks and destination latency
module instr_reg_use
  import hazard_pkg::*;
#(
  parameter int NREG     = 8,
  parameter int LOAD_LAT = 3,
  parameter int ADD_LAT  = 1
) (
  input  logic [7:0]      i_instr,
  output logic [NREG-1:0] o_src_mask,
  output logic [NREG-1:0] o_dest_mask,
  output logic [2:0]      o_dest_lat
);
  logic [1:0]      w_op;
  logic [NREG-1:0] w_ra_oh;
  logic [NREG-1:0] w_rb_oh;
  always_comb begin
    w_op        = i_instr[OP_HI:OP_LO];
    w_ra_oh     = NREG'(1) << i_instr[RA_HI:RA_LO];
    w_rb_oh     = NREG'(1) << i_instr[RB_HI:RB_LO];
    o_src_mask  = (w_op == OP_NOP) ? '0 : (w_op == OP_LOAD) ? w_rb_oh : (w_ra_oh | w_rb_oh);
    o_dest_mask = (w_op == OP_LOAD || w_op == OP_ADD) ? w_ra_oh : '0;
    o_dest_lat  = (w_op == OP_LOAD) ? 3'(LOAD_LAT) : (w_op == OP_STORE) ? 3'd0 : 3'(ADD_LAT);
  end
endmodule

// File: rtl/hazard_issue_ctrl.sv
// hazard_issue_ctrl: in-order issue slot that holds an instruction until its registers are free of in-flight writes
module hazard_issue_ctrl
  import hazard_pkg::*;
#(
  parameter int NREG     = 8,
  parameter int LOAD_LAT = 3,
  parameter int ADD_LAT  = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_instr,
  output logic             in_ready,
  output logic             out_valid,
  output logic [7:0]       out_instr,
  input  logic             out_ready,
  output logic [2:0]       hazard,
  output logic [CNT_W-1:0] stall_cnt
);
  logic             r_held_v;
  logic [7:0]       r_instr;
  logic [2:0]       r_timer [NREG];
  logic [CNT_W-1:0] r_stall;
  logic [NREG-1:0]  w_src;
  logic [NREG-1:0]  w_dest;
  logic [NREG-1:0]  w_busy;
  logic [2:0]       w_lat;
  logic             w_raw;
  logic             w_waw;
  logic             w_issue;

  instr_reg_use #(
    .NREG(NREG),
    .LOAD_LAT(LOAD_LAT),
    .ADD_LAT(ADD_LAT)
  ) u_use (
    .i_instr(r_instr),
    .o_src_mask(w_src),
    .o_dest_mask(w_dest),
    .o_dest_lat(w_lat)
  );

  always_comb begin
    for (int i = 0; i < NREG; i++) w_busy[i] = r_timer[i] != 3'd0;
    w_raw          = r_held_v & |(w_src & w_busy);
    w_waw          = r_held_v & |(w_dest & w_busy);
    out_valid      = !rst & r_held_v & !w_raw & !w_waw;
    w_issue        = out_valid & out_ready;
    in_ready       = !rst & (!r_held_v | w_issue);
    hazard         = '0;
    hazard[HZ_RAW] = w_raw;
    hazard[HZ_WAR] = 1'b0;
    hazard[HZ_WAW] = w_waw;
  end

  assign out_instr = r_instr;
  assign stall_cnt = r_stall;

  // An issuing producer reloads its destination timer, taking priority over the decrement
  always_ff @(posedge clk) begin
    if (rst) begin
      r_held_v <= 1'b0;
      r_instr  <= '0;
      r_stall  <= '0;
      for (int i = 0; i < NREG; i++) r_timer[i] <= '0;
    end else begin
      if (in_valid & in_ready) begin
        r_held_v <= 1'b1;
        r_instr  <= in_instr;
      end else if (w_issue) begin
        r_held_v <= 1'b0;
      end
      if ((w_raw | w_waw) & ~&r_stall) r_stall <= r_stall + CNT_W'(1);
      for (int i = 0; i < NREG; i++)
        r_timer[i] <= (w_issue & w_dest[i]) ? w_lat : w_busy[i] ? r_timer[i] - 3'd1 : r_timer[i];
    end
  end
endmodule

// File: tb/tb_hazard_issue_ctrl.sv
// tb_hazard_issue_ctrl: vector table, directed hazard sequences and random traffic against a ready-time model
module tb_hazard_issue_ctrl;
  logic        clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  in_instr, out_instr;
  logic [2:0]  hazard;
  logic [15:0] stall_cnt;
  int n_pass = 0;
  int n_tot = 0;

  hazard_issue_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_instr(out_instr), .out_ready(out_ready),
    .hazard(hazard), .stall_cnt(stall_cnt)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Model: each register records the first cycle at which it is free again
  int         ready_at [8];
  int         cyc = 0;
  bit         m_hv, m_raw, m_waw, m_ov, m_ir;
  logic [7:0] m_hi;
  int         m_stall;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic void dec(input logic [7:0] x, output int d, output int s0, output int s1);
    int ra = int'(x[5:3]);
    int rb = int'(x[2:0]);
    d = -1; s0 = -1; s1 = -1;
    case (x[7:6])
      2'b01: begin d = ra; s0 = rb; end
      2'b10: begin s0 = ra; s1 = rb; end
      2'b11: begin d = ra; s0 = ra; s1 = rb; end
      default: ;
    endcase
  endfunction

  function automatic bit busy(input int r);
    return r >= 0 && ready_at[r] > cyc;
  endfunction

  task automatic model_eval();
    int d, s0, s1;
    dec(m_hi, d, s0, s1);
    m_raw = m_hv && (busy(s0) || busy(s1));
    m_waw = m_hv && busy(d);
    m_ov  = !rst && m_hv && !m_raw && !m_waw;
    m_ir  = !rst && (!m_hv || (m_ov && out_ready));
  endtask

  task automatic model_step();
    int d, s0, s1;
    bit iss;
    model_eval();
    if (rst) begin
      m_hv = 0; m_hi = 0; m_stall = 0;
      foreach (ready_at[i]) ready_at[i] = 0;
    end else begin
      dec(m_hi, d, s0, s1);
      iss = m_ov && out_ready;
      if (iss && d >= 0) ready_at[d] = cyc + 1 + (m_hi[7:6] == 2'b01 ? 3 : 1);
      if ((m_raw || m_waw) && m_stall < 65535) m_stall++;
      if (in_valid && m_ir) begin
        m_hv = 1; m_hi = in_instr;
      end else if (iss) m_hv = 0;
    end
    cyc++;
  endtask

  task automatic drive(input logic r, input logic v, input logic [7:0] ins, input logic rdy);
    rst = r; in_valid = v; in_instr = ins; out_ready = rdy;
    @(negedge clk);
    model_eval();
    chk("mdl_out_valid", int'(out_valid), int'(m_ov));
    chk("mdl_in_ready", int'(in_ready), int'(m_ir));
    chk("mdl_hazard", int'(hazard), int'({m_raw, 1'b0, m_waw}));
    chk("mdl_stall_cnt", int'(stall_cnt), m_stall);
    if (m_hv) chk("mdl_out_instr", int'(out_instr), int'(m_hi));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic pair(input string nm, input logic [7:0] a, input logic [7:0] b, input int exp_c,
                      input logic [2:0] exp_hz);
    int at = -1;
    int st = -1;
    logic [2:0] hz1 = '0;
    drive(1, 0, 8'h00, 1); tick();
    drive(0, 1, a, 1); tick();
    drive(0, 1, b, 1);
    chk({nm, "_first_issue"}, int'({out_valid, out_instr}), int'({1'b1, a}));
    tick();
    for (int k = 1; k <= 12 && at < 0; k++) begin
      drive(0, 0, 8'h00, 1);
      if (k == 1) hz1 = hazard;
      if (out_valid) begin
        at = k; st = int'(stall_cnt);
      end
      tick();
    end
    chk({nm, "_issue_cycle"}, at, exp_c);
    chk({nm, "_hazard"}, int'(hz1), int'(exp_hz));
    chk({nm, "_stall_cnt"}, st, exp_c - 1);
  endtask

  typedef struct {
    logic r, v, rdy, ev, eir, ci;
    logic [7:0] ins, eoi;
    logic [2:0] ehz;
    int est;
  } vec_t;
  vec_t tbl [8];

  initial begin
    int at;
    // Scenario 1: load r3, then store reading r3
    tbl[0] = '{r:1, v:0, rdy:1, ev:0, eir:0, ci:1, ins:8'h00, eoi:8'h00, ehz:3'b000, est:0};
    tbl[1] = '{r:0, v:1, rdy:1, ev:0, eir:1, ci:1, ins:8'h5D, eoi:8'h00, ehz:3'b000, est:0};
    tbl[2] = '{r:0, v:1, rdy:1, ev:1, eir:1, ci:1, ins:8'h98, eoi:8'h5D, ehz:3'b000, est:0};
    tbl[3] = '{r:0, v:0, rdy:1, ev:0, eir:0, ci:1, ins:8'h00, eoi:8'h98, ehz:3'b100, est:0};
    tbl[4] = '{r:0, v:0, rdy:1, ev:0, eir:0, ci:1, ins:8'h00, eoi:8'h98, ehz:3'b100, est:1};
    tbl[5] = '{r:0, v:0, rdy:1, ev:0, eir:0, ci:1, ins:8'h00, eoi:8'h98, ehz:3'b100, est:2};
    tbl[6] = '{r:0, v:0, rdy:1, ev:1, eir:1, ci:1, ins:8'h00, eoi:8'h98, ehz:3'b000, est:3};
    tbl[7] = '{r:0, v:0, rdy:1, ev:0, eir:1, ci:0, ins:8'h00, eoi:8'h00, ehz:3'b000, est:3};
    rst = 1; in_valid = 0; in_instr = 0; out_ready = 0;
    @(posedge clk); model_step(); #1;
    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].ins, tbl[i].rdy);
      chk($sformatf("tbl%0d_out_valid", i), int'(out_valid), int'(tbl[i].ev));
      chk($sformatf("tbl%0d_in_ready", i), int'(in_ready), int'(tbl[i].eir));
      chk($sformatf("tbl%0d_hazard", i), int'(hazard), int'(tbl[i].ehz));
      chk($sformatf("tbl%0d_stall_cnt", i), int'(stall_cnt), tbl[i].est);
      if (tbl[i].ci) chk($sformatf("tbl%0d_out_instr", i), int'(out_instr), int'(tbl[i].eoi));
      tick();
    end
    pair("s2_waw", 8'h5D, 8'h59, 4, 3'b001);
    pair("s3_raw_waw", 8'h5D, 8'hD9, 4, 3'b101);
    pair("s4_add_chain", 8'hD3, 8'hE2, 2, 3'b100);
    // Scenario 5: backpressure, then the stream drains; 0x98 reads r3 so it waits on the load
    drive(1, 0, 8'h00, 1); tick();
    drive(0, 1, 8'h5D, 1); tick();
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 8'hE2, 0);
      chk("s5_hold_instr", int'(out_instr), 8'h5D);
      chk("s5_in_ready", int'(in_ready), 0);
      chk("s5_stall_cnt", int'(stall_cnt), 0);
      tick();
    end
    drive(0, 1, 8'hE2, 1);
    chk("s5_issue_load", int'({out_valid, out_instr}), int'({1'b1, 8'h5D}));
    tick();
    drive(0, 1, 8'h98, 1);
    chk("s5_issue_add", int'({out_valid, out_instr}), int'({1'b1, 8'hE2}));
    tick();
    at = -1;
    for (int k = 2; k <= 12 && at < 0; k++) begin
      drive(0, 0, 8'h00, 1);
      if (out_valid) at = k;
      tick();
    end
    chk("s5_store_issue_cycle", at, 4);
    // Scenario 6: reset while the store is stalled
    drive(1, 0, 8'h00, 1); tick();
    drive(0, 1, 8'h5D, 1); tick();
    drive(0, 1, 8'h98, 1); tick();
    drive(0, 0, 8'h00, 1);
    chk("s6_c1_hazard", int'(hazard), 3'b100);
    tick();
    drive(1, 0, 8'h00, 1);
    chk("s6_rst_out_valid", int'(out_valid), 0);
    chk("s6_rst_in_ready", int'(in_ready), 0);
    tick();
    drive(0, 1, 8'h98, 1);
    chk("s6_post_out_valid", int'(out_valid), 0);
    chk("s6_post_hazard", int'(hazard), 0);
    chk("s6_post_stall_cnt", int'(stall_cnt), 0);
    chk("s6_post_in_ready", int'(in_ready), 1);
    tick();
    drive(0, 0, 8'h00, 1);
    chk("s6_store_issue", int'({out_valid, out_instr, hazard}), int'({1'b1, 8'h98, 3'b000}));
    tick();
    drive(0, 0, 8'h00, 1);
    chk("s6_final_stall_cnt", int'(stall_cnt), 0);
    tick();
    for (int k = 0; k < 3000; k++) begin
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7, 8'($urandom),
            $urandom_range(0, 3) != 0);
      tick();
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
